hazard_forward_unit: RTL and testbench

Hazard-detection and operand-forwarding controller for the SPARC integer pipeline. It tracks the destination register of the instructions in EX, MEM and WB in its own internal shift pipeline. From that state and the register sources of the instruction in ID it generates:
- the 2-bit select of each ID/EX operand `mux_4x1`;
- the select of the control-word NOP mux;
- the PC and IF/ID write enables that implement load-use stalls.

It sits directly upstream of the operand and control muxes and drives their `S` inputs.

---
 rtl/hazard_forward_unit.sv | 120 ++++++++++++
 tb/tb_hazard_forward_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Load-use hazard and operand-forwarding control for the integer pipeline.
// Optional stall/flush counters: define HAZARD_UNIT_STATS_EN.
module hazard_forward_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_rd_we,
  input  logic        id_is_load,
  input  logic        flush,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        ctrl_nop_sel,
  output logic        pc_we,
  output logic        ifid_we,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } ent_t;

  ent_t ex_q, mem_q, wb_q, ex_d;

  logic a_ex, a_mem, a_wb;
  logic b_ex, b_mem, b_wb;
  logic stall, eff_stall;
  logic unused_ld;

  function automatic logic hit(
    input ent_t       e,
    input logic [4:0] rs,
    input logic       used
  );
    return used && (rs != 5'd0) && e.v && e.we && (e.rd == rs);
  endfunction

  assign a_ex  = hit(ex_q,  id_rs1, id_rs1_used);
  assign a_mem = hit(mem_q, id_rs1, id_rs1_used);
  assign a_wb  = hit(wb_q,  id_rs1, id_rs1_used);
  assign b_ex  = hit(ex_q,  id_rs2, id_rs2_used);
  assign b_mem = hit(mem_q, id_rs2, id_rs2_used);
  assign b_wb  = hit(wb_q,  id_rs2, id_rs2_used);

  assign stall     = id_valid & ex_q.ld & (a_ex | b_ex);
  assign eff_stall = stall & ~flush;

  assign ctrl_nop_sel = eff_stall | flush | ~id_valid;
  assign pc_we        = ~eff_stall;
  assign ifid_we      = ~eff_stall;

  // Load flag only matters while the producer sits in EX.
  assign unused_ld = mem_q.ld ^ wb_q.ld;

  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (!stall) begin
      if (a_ex)       fwd_a_sel = 2'b01;
      else if (a_mem) fwd_a_sel = 2'b10;
      else if (a_wb)  fwd_a_sel = 2'b11;
      if (b_ex)       fwd_b_sel = 2'b01;
      else if (b_mem) fwd_b_sel = 2'b10;
      else if (b_wb)  fwd_b_sel = 2'b11;
    end
  end

  always_comb begin
    ex_d = '0;
    if (!(eff_stall | flush)) begin
      ex_d.v  = id_valid;
      ex_d.rd = id_rd;
      ex_d.we = id_rd_we;
      ex_d.ld = id_is_load;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

`ifdef HAZARD_UNIT_STATS_EN
  logic [15:0] stall_q, flush_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (eff_stall && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
      if (flush && flush_q != 16'hFFFF)
        flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 16'd0;
  assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed pins plus random stimulus
// checked every cycle against a stage-list reference model.
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used;
  logic        id_rd_we, id_is_load, flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        ctrl_nop_sel, pc_we, ifid_we;
  logic [15:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model: index 0 = EX, 1 = MEM, 2 = WB
  bit         m_v[3]  = '{0, 0, 0};
  logic [4:0] m_rd[3] = '{0, 0, 0};
  bit         m_we[3] = '{0, 0, 0};
  bit         m_ld[3] = '{0, 0, 0};
  longint     n_stall = 0;
  longint     n_flush = 0;

  hazard_forward_unit dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
    .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .ctrl_nop_sel(ctrl_nop_sel), .pc_we(pc_we), .ifid_we(ifid_we),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
    end
  endtask

  // first stage (1=EX..3=WB) whose destination matches, 0 if none
  function automatic logic [1:0] src_of(input logic [4:0] rs,
                                        input logic u);
    for (int i = 0; i < 3; i++)
      if (u && rs != 0 && m_v[i] && m_we[i] && m_rd[i] == rs)
        return 2'(i + 1);
    return 2'd0;
  endfunction

  function automatic bit m_stall();
    return id_valid && m_ld[0] &&
           (src_of(id_rs1, id_rs1_used) == 2'd1 ||
            src_of(id_rs2, id_rs2_used) == 2'd1);
  endfunction

  function automatic logic [15:0] sat(input longint n);
`ifdef HAZARD_UNIT_STATS_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return (n < 0) ? 16'hFFFF : 16'd0;
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) m_v[i] = 0;
      n_stall = 0;
      n_flush = 0;
    end else begin
      bit st, es;
      st = m_stall();
      es = st && !flush;
      for (int i = 2; i > 0; i--) begin
        m_v[i]  = m_v[i-1];
        m_rd[i] = m_rd[i-1];
        m_we[i] = m_we[i-1];
        m_ld[i] = m_ld[i-1];
      end
      m_v[0]  = (es || flush) ? 1'b0 : id_valid;
      m_rd[0] = id_rd;
      m_we[0] = id_rd_we;
      m_ld[0] = id_is_load;
      if (es) n_stall++;
      if (flush) n_flush++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit st, es;
      logic [1:0] ea, eb;
      st = m_stall();
      es = st && !flush;
      ea = st ? 2'd0 : src_of(id_rs1, id_rs1_used);
      eb = st ? 2'd0 : src_of(id_rs2, id_rs2_used);
      chk("m_fwd_a", 16'(fwd_a_sel), 16'(ea));
      chk("m_fwd_b", 16'(fwd_b_sel), 16'(eb));
      chk("m_nop", 16'(ctrl_nop_sel), 16'(es || flush || !id_valid));
      chk("m_pc_we", 16'(pc_we), 16'(!es));
      chk("m_ifid_we", 16'(ifid_we), 16'(!es));
      chk("m_stall_cnt", stall_cnt, sat(n_stall));
      chk("m_flush_cnt", flush_cnt, sat(n_flush));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit v, input logic [4:0] r1, input bit u1,
                     input logic [4:0] r2, input bit u2,
                     input logic [4:0] rd, input bit we, input bit ld,
                     input bit fl);
    id_valid = v;
    id_rs1 = r1; id_rs1_used = u1;
    id_rs2 = r2; id_rs2_used = u2;
    id_rd = rd; id_rd_we = we; id_is_load = ld;
    flush = fl;
  endtask

  initial begin
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_a", 16'(fwd_a_sel), 16'd0);
    chk("rst_pc_we", 16'(pc_we), 16'd1);
    chk("rst_nop_inv", 16'(ctrl_nop_sel), 16'd1);
    drv(1, 3, 1, 3, 1, 3, 1, 1, 0);
    #1;
    chk("rst_nop_valid", 16'(ctrl_nop_sel), 16'd0);
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;

    // EX forward
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0);
    tick();
    drv(1, 3, 1, 4, 1, 9, 1, 0, 0);
    #1;
    chk("ex_fwd_a", 16'(fwd_a_sel), 16'd1);
    chk("ex_fwd_b", 16'(fwd_b_sel), 16'd0);
    chk("ex_fwd_pc_we", 16'(pc_we), 16'd1);

    // priority and r0
    for (int k = 0; k < 3; k++) begin
      tick();
      drv(1, 0, 0, 0, 0, 5, 1, 0, 0);
    end
    tick();
    drv(1, 5, 1, 5, 1, 1, 0, 0, 0);
    #1;
    chk("prio_a", 16'(fwd_a_sel), 16'd1);
    chk("prio_b", 16'(fwd_b_sel), 16'd1);
    drv(1, 0, 1, 0, 1, 1, 0, 0, 0);
    #1;
    chk("r0_a", 16'(fwd_a_sel), 16'd0);
    chk("r0_b", 16'(fwd_b_sel), 16'd0);

    // load-use
    tick();
    drv(1, 0, 0, 0, 0, 7, 1, 1, 0);
    tick();
    drv(1, 7, 1, 0, 0, 8, 1, 0, 0);
    #1;
    chk("lu_pc_we", 16'(pc_we), 16'd0);
    chk("lu_nop", 16'(ctrl_nop_sel), 16'd1);
    chk("lu_a", 16'(fwd_a_sel), 16'd0);
    tick();
    chk("lu2_a", 16'(fwd_a_sel), 16'd2);
    chk("lu2_pc_we", 16'(pc_we), 16'd1);
    chk("lu2_nop", 16'(ctrl_nop_sel), 16'd0);

    // flush with stall
    drv(1, 0, 0, 0, 0, 7, 1, 1, 0);
    tick();
    drv(1, 7, 1, 0, 0, 8, 1, 0, 1);
    #1;
    chk("fl_pc_we", 16'(pc_we), 16'd1);
    chk("fl_nop", 16'(ctrl_nop_sel), 16'd1);
    tick();
    flush = 1'b0;
    #1;
    chk("fl2_a", 16'(fwd_a_sel), 16'd2);
    chk("fl2_pc_we", 16'(pc_we), 16'd1);

    // reset mid-stall
    tick();
    drv(1, 0, 0, 0, 0, 7, 1, 1, 0);
    tick();
    drv(1, 0, 0, 7, 1, 8, 1, 0, 0);
    #1;
    chk("rs_pre_pc_we", 16'(pc_we), 16'd0);
    reset = 1'b1;
    #1;
    chk("rs_pc_we", 16'(pc_we), 16'd1);
    chk("rs_a", 16'(fwd_a_sel), 16'd0);
    chk("rs_b", 16'(fwd_b_sel), 16'd0);
    chk("rs_stall_cnt", stall_cnt, 16'd0);
    tick();
    reset = 1'b0;

    // random phase
    for (int c = 0; c < 3000; c++) begin
      bit ld;
      ld = ($urandom_range(0, 3) == 0);
      drv($urandom_range(0, 7) != 0,
          5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
          5'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
          5'($urandom_range(0, 7)), $urandom_range(0, 4) != 0,
          ld, $urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;

`ifdef HAZARD_UNIT_STATS_EN
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int c = 0; c < 70000; c++) tick();
    chk("sat_flush", flush_cnt, 16'hFFFF);
    tick();
    tick();
    chk("sat_flush_hold", flush_cnt, 16'hFFFF);
`endif

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
